qed_inst_filter: RTL and testbench
==================================

// Module: qed_inst_filter
// PURPOSE
//  Parametrised, stateful instruction filter at the SQED fetch boundary. Decodes each
//  issued 32-bit RV32I word and flags it legal per register-bound and opcode rules.
//  Tracks the QED phase with an FSM: pre-commit, SW hold-off, post-commit, budget exhausted.
//  Drives a registered issue budget and a sticky illegal-issue flag; assumes optional.
// PARAMETERS
//  REG_LIMIT     16  rs1/rs2/rd must be < REG_LIMIT (original-half register file)
//  LW_IMM_LIMIT  64  LW legal only if imm12 < LW_IMM_LIMIT, imm[11:10]==0, rs1==x0
//  SW_IMM7_LIMIT 2   SW legal only if imm7 < SW_IMM7_LIMIT, imm7[6:5]==0, rs1==x0
//  SW_HOLDOFF    1   cycles after first sif_commit before SW becomes legal (>=0)
//  MAX_ISSUE     64  non-NOP issue budget; CW = $clog2(MAX_ISSUE+1)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   synchronous active-low reset
//  instruction      in   32  instruction word presented for issue
//  inst_valid       in   1   instruction is issued this cycle
//  sif_commit       in   1   SIF commit indication from the core
//  allowed          out  1   comb: instruction legal in current phase
//  phase            out  2   0 PRE_TC, 1 HOLDOFF, 2 POST_TC, 3 EXHAUSTED (registered)
//  issue_count      out  CW  non-NOP legal issues so far (registered, saturating)
//  budget_exhausted out  1   phase==EXHAUSTED
//  illegal_seen     out  1   sticky: inst_valid seen with allowed==0 (registered)
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): phase=PRE_TC, issue_count=0, illegal_seen=0, hold cnt=0;
//   applies mid-operation, discards all state; allowed stays purely combinational.
//  Decode classes (comb): I (ADDI,SLTI,SLTIU,XORI,ORI,ANDI; SLLI/SRLI funct7=0, SRAI
//   funct7=0100000), R (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND, exact funct7), LW, SW,
//   JAL, LUI, AUIPC (rd bound only), NOP = opcode 7'h7F. All register fields < REG_LIMIT.
//  allowed: PRE_TC/HOLDOFF -> I|R|LW|JAL|LUI|AUIPC|NOP; POST_TC -> adds SW;
//   EXHAUSTED -> NOP only.
//  FSM (advances at posedge, rst_n==1):
//   PRE_TC: sif_commit==1 -> HOLDOFF (hold cnt=0), or POST_TC directly if SW_HOLDOFF==0.
//   HOLDOFF: hold cnt++ each cycle; at hold cnt==SW_HOLDOFF-1 -> POST_TC.
//   POST_TC: stays; sif_commit is sticky once seen, later deassertion ignored.
//   any phase: issue that makes issue_count reach MAX_ISSUE -> EXHAUSTED (priority over
//    sif_commit transitions the same cycle). EXHAUSTED exits only by reset.
//  issue_count: +1 at posedge when inst_valid && allowed && !NOP; saturates at MAX_ISSUE.
//  illegal_seen: set at posedge when inst_valid && !allowed; cleared only by reset.
//  Latency: phase/count/flag update 1 cycle after the issue; allowed uses pre-update phase.
//  Simultaneous sif_commit and SW in PRE_TC: SW judged against PRE_TC -> illegal.
// CONFIGURATION
//  QED_INST_ASSUME_EN defined: adds assume property @(posedge clk) disable iff (!rst_n)
//   inst_valid |-> allowed; formal constrains stimulus, illegal_seen provably stays 0.
//  Undefined: no SVA emitted; block is a pure monitor, illegal_seen reports violations.
// TESTING
//  1 reset, inst_valid=1, 32'h00510093 (ADDI x1,x2,5) -> allowed=1, next issue_count=1.
//  2 PRE_TC, 32'h00102023 (SW x1,0(x0)) -> allowed=0, illegal_seen=1 next cycle, sticky.
//  3 sif_commit pulse 1 cycle, SW_HOLDOFF=1 -> phase 1 then 2; SW allowed=1 from POST_TC
//    even with sif_commit back at 0.
//  4 32'h00510813 (ADDI x16) -> allowed=0 in every phase; 32'h0000007F -> allowed=1,
//    issue_count unchanged.
//  5 MAX_ISSUE=4, issue 4 ADDIs -> phase=3, budget_exhausted=1; next ADDI allowed=0,
//    issue_count stays 4; NOP allowed=1.
//  6 rst_n=0 for one cycle while in POST_TC with illegal_seen=1 -> phase=0, count=0, flag=0.

Source files
------------

// File: rtl/qed_inst_filter.sv
// SQED fetch-boundary RV32I filter with QED phase FSM; QED_INST_ASSUME_EN adds a formal assume.
// allowed is combinational on the current phase; phase/count/flag update 1 cycle after issue; no backpressure.
module qed_inst_filter #(
    parameter int REG_LIMIT     = 16,
    parameter int LW_IMM_LIMIT  = 64,
    parameter int SW_IMM7_LIMIT = 2,
    parameter int SW_HOLDOFF    = 1,
    parameter int MAX_ISSUE     = 64,
    localparam int CW           = $clog2(MAX_ISSUE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   instruction,
    input  logic          inst_valid,
    input  logic          sif_commit,
    output logic          allowed,
    output logic [1:0]    phase,
    output logic [CW-1:0] issue_count,
    output logic          budget_exhausted,
    output logic          illegal_seen
);
    localparam int HW = (SW_HOLDOFF > 1) ? $clog2(SW_HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (SW_HOLDOFF > 0) ? HW'(SW_HOLDOFF - 1) : '0;
    localparam logic [5:0]    REG_LIM   = 6'(REG_LIMIT);
    localparam logic [12:0]   LW_LIM    = 13'(LW_IMM_LIMIT);
    localparam logic [7:0]    SW_LIM    = 8'(SW_IMM7_LIMIT);
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_ISSUE);
    localparam logic [CW-1:0] LAST_C    = CW'(MAX_ISSUE - 1);

    typedef enum logic [1:0] {PRE_TC, HOLDOFF, POST_TC, EXHAUSTED} phase_t;

    phase_t          state, state_next;
    logic [HW-1:0]   hold_cnt, hold_next;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic        rd_ok, rs1_ok, rs2_ok;
    logic        is_i, is_r, is_lw, is_sw, is_jal, is_lui, is_auipc, is_nop;
    logic        base_legal, issue, count_inc, count_hit;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign imm12  = instruction[31:20];

    assign rd_ok  = {1'b0, rd}  < REG_LIM;
    assign rs1_ok = {1'b0, rs1} < REG_LIM;
    assign rs2_ok = {1'b0, rs2} < REG_LIM;

    always_comb begin
        is_i = 1'b0;
        is_r = 1'b0;
        if (opcode == 7'h13 && rd_ok && rs1_ok) begin
            case (funct3)
                3'b001:  is_i = (funct7 == 7'h00);
                3'b101:  is_i = (funct7 == 7'h00) || (funct7 == 7'h20);
                default: is_i = 1'b1;
            endcase
        end
        if (opcode == 7'h33 && rd_ok && rs1_ok && rs2_ok) begin
            case (funct3)
                3'b000, 3'b101: is_r = (funct7 == 7'h00) || (funct7 == 7'h20);
                default:        is_r = (funct7 == 7'h00);
            endcase
        end
    end

    // Loads/stores are confined to a small x0-based window of data memory.
    assign is_lw    = (opcode == 7'h03) && (funct3 == 3'b010) && rd_ok && (rs1 == 5'd0)
                      && ({1'b0, imm12} < LW_LIM) && (imm12[11:10] == 2'b00);
    assign is_sw    = (opcode == 7'h23) && (funct3 == 3'b010) && rs2_ok && (rs1 == 5'd0)
                      && ({1'b0, funct7} < SW_LIM) && (funct7[6:5] == 2'b00);
    assign is_jal   = (opcode == 7'h6F) && rd_ok;
    assign is_lui   = (opcode == 7'h37) && rd_ok;
    assign is_auipc = (opcode == 7'h17) && rd_ok;
    assign is_nop   = (opcode == 7'h7F);

    assign base_legal = is_i || is_r || is_lw || is_jal || is_lui || is_auipc || is_nop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= PRE_TC;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    assign issue     = inst_valid && allowed && !is_nop;
    assign count_inc = issue && (issue_count != MAX_C);
    assign count_hit = count_inc && (issue_count == LAST_C);

    // Exhausting the budget wins over any commit-driven transition in the same cycle.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        if (count_hit) begin
            state_next = EXHAUSTED;
        end else begin
            case (state)
                PRE_TC: begin
                    if (sif_commit) begin
                        state_next = (SW_HOLDOFF == 0) ? POST_TC : HOLDOFF;
                        hold_next  = '0;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == HOLD_LAST) state_next = POST_TC;
                    else                       hold_next  = hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        allowed = 1'b0;
        case (state)
            PRE_TC, HOLDOFF: allowed = base_legal;
            POST_TC:         allowed = base_legal || is_sw;
            EXHAUSTED:       allowed = is_nop;
            default:         allowed = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_count  <= '0;
            illegal_seen <= 1'b0;
        end else begin
            if (count_inc)               issue_count  <= issue_count + 1'b1;
            if (inst_valid && !allowed)  illegal_seen <= 1'b1;
        end
    end

    assign phase            = state;
    assign budget_exhausted = (state == EXHAUSTED);

`ifdef QED_INST_ASSUME_EN
    inst_legal_a: assume property (@(posedge clk) disable iff (!rst_n) inst_valid |-> allowed);
`endif

endmodule

// File: tb/tb_qed_inst_filter.sv
// Directed + randomized bench for qed_inst_filter (MAX_ISSUE=4, SW_HOLDOFF=1) against a phase/budget model.
module tb_qed_inst_filter;
    localparam int MAXI = 4;
    localparam int HOLD = 1;
    localparam logic [31:0] ADDI   = 32'h00510093;
    localparam logic [31:0] SW1    = 32'h00102023;
    localparam logic [31:0] ADDI16 = 32'h00510813;
    localparam logic [31:0] NOP    = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = NOP;
    logic        inst_valid = 1'b0;
    logic        sif_commit = 1'b0;
    logic        allowed;
    logic [1:0]  phase;
    logic [2:0]  issue_count;
    logic        budget_exhausted;
    logic        illegal_seen;

    int passed = 0;
    int total  = 0;

    int m_cyc = 0, m_commit_at = -1, m_count = 0;
    bit m_exh = 0, m_ill = 0;

    qed_inst_filter #(.SW_HOLDOFF(HOLD), .MAX_ISSUE(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .inst_valid(inst_valid),
        .sif_commit(sif_commit), .allowed(allowed), .phase(phase), .issue_count(issue_count),
        .budget_exhausted(budget_exhausted), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    // 0 illegal, 1 legal outside EXHAUSTED, 2 store (legal only post-commit), 3 NOP
    function automatic int classify(input logic [31:0] w);
        int op, rd, f3, rs1, rs2, f7, imm;
        bit rok, r1ok, r2ok;
        op = int'(w[6:0]); rd = int'(w[11:7]); f3 = int'(w[14:12]);
        rs1 = int'(w[19:15]); rs2 = int'(w[24:20]); f7 = int'(w[31:25]); imm = int'(w[31:20]);
        rok = rd < 16; r1ok = rs1 < 16; r2ok = rs2 < 16;
        case (op)
            'h7F: return 3;
            'h13: if (rok && r1ok) begin
                      if (f3 == 1) return (f7 == 0) ? 1 : 0;
                      if (f3 == 5) return (f7 == 0 || f7 == 32) ? 1 : 0;
                      return 1;
                  end
            'h33: if (rok && r1ok && r2ok) begin
                      if (f3 == 0 || f3 == 5) return (f7 == 0 || f7 == 32) ? 1 : 0;
                      return (f7 == 0) ? 1 : 0;
                  end
            'h03: return (f3 == 2 && rok && rs1 == 0 && imm < 64) ? 1 : 0;
            'h23: return (f3 == 2 && r2ok && rs1 == 0 && f7 < 2) ? 2 : 0;
            'h6F, 'h37, 'h17: return rok ? 1 : 0;
            default: return 0;
        endcase
        return 0;
    endfunction

    function automatic int model_phase();
        if (m_exh) return 3;
        if (m_commit_at < 0) return 0;
        return ((m_cyc - m_commit_at) <= HOLD) ? 1 : 2;
    endfunction

    function automatic bit model_allowed(input int k, input int ph);
        if (k == 3) return 1;
        if (ph == 3) return 0;
        if (k == 1) return 1;
        if (k == 2) return ph == 2;
        return 0;
    endfunction

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [6:0] rnd_f7();
        case ($urandom_range(0, 2))
            0: return 7'h00;
            1: return 7'h20;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: return {r[31:20], rnd_reg(), r[14:12], rnd_reg(), 7'h13};
            1: return {rnd_f7(), r[24:20], rnd_reg(), r[14:12], rnd_reg(), 7'h13};
            2: return {rnd_f7(), rnd_reg(), rnd_reg(), r[14:12], rnd_reg(), 7'h33};
            3: return {(r[0] ? 12'(r[27:22]) : r[31:20]), (r[1] ? 5'd0 : rnd_reg()),
                       (r[2] ? 3'b010 : r[14:12]), rnd_reg(), 7'h03};
            4: return {(r[0] ? 7'(r[25]) : r[31:25]), rnd_reg(), (r[1] ? 5'd0 : rnd_reg()),
                       (r[2] ? 3'b010 : r[14:12]), r[11:7], 7'h23};
            5: return {r[31:12], rnd_reg(), 7'h6F};
            6: return {r[31:12], rnd_reg(), r[3] ? 7'h37 : 7'h17};
            7: return {r[31:7], 7'h7F};
            default: return r;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One cycle: drive, compare outputs against model (plus optional directed allowed), clock, update model.
    task automatic step(input logic [31:0] ins, input logic v, input logic c, input logic r,
                        input int exp_a, input string tag);
        int ph, k;
        bit a;
        @(negedge clk);
        instruction = ins; inst_valid = v; sif_commit = c; rst_n = r;
        #1;
        ph = model_phase();
        k  = classify(ins);
        a  = model_allowed(k, ph);
        chk({tag, ":allowed"}, 32'(allowed), 32'(a));
        chk({tag, ":phase"}, 32'(phase), 32'(ph));
        chk({tag, ":count"}, 32'(issue_count), 32'(m_count));
        chk({tag, ":exh"}, 32'(budget_exhausted), 32'(m_exh));
        chk({tag, ":ill"}, 32'(illegal_seen), 32'(m_ill));
        if (exp_a >= 0) chk({tag, ":dir_allowed"}, 32'(allowed), 32'(exp_a));
        @(posedge clk);
        if (!r) begin
            m_cyc = 0; m_commit_at = -1; m_count = 0; m_exh = 0; m_ill = 0;
        end else begin
            if (v && !a) m_ill = 1;
            if (v && a && k != 3 && m_count < MAXI) begin
                m_count++;
                if (m_count == MAXI) m_exh = 1;
            end
            if (c && m_commit_at < 0) m_commit_at = m_cyc;
            m_cyc++;
        end
    endtask

    task automatic expect_regs(input string tag, input int ph, input int cnt, input int ill);
        #1;
        chk({tag, ":phase"}, 32'(phase), 32'(ph));
        chk({tag, ":count"}, 32'(issue_count), 32'(cnt));
        chk({tag, ":exh"}, 32'(budget_exhausted), 32'(ph == 3));
        chk({tag, ":ill"}, 32'(illegal_seen), 32'(ill));
    endtask

    initial begin
        step(NOP, 0, 0, 0, -1, "rst");
        expect_regs("reset", 0, 0, 0);
        step(ADDI, 1, 0, 1, 1, "t1");
        expect_regs("t1", 0, 1, 0);
        step(SW1, 1, 0, 1, 0, "t2");
        expect_regs("t2", 0, 1, 1);
        step(NOP, 0, 0, 1, -1, "t2_idle");
        expect_regs("t2_sticky", 0, 1, 1);
        step(ADDI16, 1, 1, 1, 0, "t3_commit");
        expect_regs("t3_hold", 1, 1, 1);
        step(SW1, 1, 0, 1, 0, "t3_sw_hold");
        expect_regs("t3_post", 2, 1, 1);
        step(SW1, 1, 0, 1, 1, "t3_sw_post");
        expect_regs("t3_sw_cnt", 2, 2, 1);
        step(ADDI16, 1, 0, 1, 0, "t4_x16_post");
        step(NOP, 1, 0, 1, 1, "t4_nop");
        expect_regs("t4_nop_cnt", 2, 2, 1);
        step(ADDI, 1, 0, 1, 1, "t5_a3");
        step(ADDI, 1, 0, 1, 1, "t5_a4");
        expect_regs("t5_exh", 3, 4, 1);
        step(ADDI, 1, 0, 1, 0, "t5_over");
        step(ADDI16, 1, 0, 1, 0, "t4_x16_exh");
        step(NOP, 1, 0, 1, 1, "t5_nop");
        expect_regs("t5_sat", 3, 4, 1);
        step(NOP, 0, 0, 0, -1, "t6_rst_exh");
        expect_regs("t6a", 0, 0, 0);
        step(SW1, 1, 1, 1, 0, "sw_with_commit");
        step(NOP, 0, 0, 1, -1, "hold");
        step(ADDI16, 1, 0, 1, 0, "t4_x16_post2");
        expect_regs("t6_pre", 2, 0, 1);
        step(NOP, 0, 0, 0, -1, "t6_rst_post");
        expect_regs("t6b", 0, 0, 0);
        step(ADDI, 1, 1, 1, 1, "exh_vs_commit1");
        step(ADDI, 1, 0, 1, 1, "exh_vs_commit2");
        step(ADDI, 1, 0, 1, 1, "exh_vs_commit3");
        step(ADDI, 1, 1, 1, 1, "exh_vs_commit4");
        expect_regs("exh_prio", 3, 4, 0);
        step(NOP, 0, 0, 0, -1, "rnd_rst");
        for (int i = 0; i < 2000; i++) begin
            step(gen_inst(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) != 0), -1, "rnd");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
